ceyloniac_multicycle_ctrl_fsm: RTL and testbench

Main control state machine for the ceyloniac multicycle datapath. Decodes the 6-bit opcode latched in the instruction register and sequences each instruction through fetch, decode, execute, memory and writeback cycles. It drives every datapath select and write-enable, including the 2-bit ALU input-B source select and the ALU input-A select. It waits on a memory-ready handshake for instruction and data accesses.

---
 rtl/ceyloniac_multicycle_ctrl_fsm_pkg.sv | 67 ++++++
 rtl/ceyloniac_ctrl_output_decode.sv | 70 +++++++
 rtl/ceyloniac_multicycle_ctrl_fsm.sv | 101 ++++++++++
 tb/tb_ceyloniac_multicycle_ctrl_fsm.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ceyloniac_multicycle_ctrl_fsm_pkg.sv
// Shared definitions for the ceyloniac multicycle controller: state
// encodings, opcodes, datapath select encodings and the control word.
package ceyloniac_multicycle_ctrl_fsm_pkg;

  localparam int OPCODE_WIDTH = 6;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_WIDTH-1:0] OP_J     = 6'b000010;
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_WIDTH-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_WIDTH-1:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALU_SRC_B_REG     = 2'b00;
  localparam logic [1:0] ALU_SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] ALU_SRC_B_IMM     = 2'b10;
  localparam logic [1:0] ALU_SRC_B_IMM_SH2 = 2'b11;

  localparam logic ALU_SRC_A_PC  = 1'b0;
  localparam logic ALU_SRC_A_REG = 1'b1;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // Raw per-state control word; enables are gated in the top module.
  typedef struct packed {
    logic [1:0] alu_src_b;
    logic       alu_src_a;
    logic [1:0] alu_op;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
  } ctrl_word_t;

  function automatic logic is_legal_op(input logic [OPCODE_WIDTH-1:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/ceyloniac_ctrl_output_decode.sv
// Combinational state-to-control-word decode (Moore outputs).
module ceyloniac_ctrl_output_decode
  import ceyloniac_multicycle_ctrl_fsm_pkg::*;
(
  input  state_t     state,
  output ctrl_word_t ctrl
);

  // Map each state to its datapath selects and raw enables; anything
  // unlisted stays 0, including the unreachable codes.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = ALU_SRC_B_FOUR;
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
      end
      S_DECODE: begin
        ctrl.alu_src_b = ALU_SRC_B_IMM_SH2;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = ALU_SRC_A_REG;
        ctrl.alu_src_b = ALU_SRC_B_IMM;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = ALU_SRC_A_REG;
        ctrl.alu_src_b = ALU_SRC_B_REG;
        ctrl.alu_op    = ALU_OP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = ALU_SRC_A_REG;
        ctrl.alu_src_b     = ALU_SRC_B_REG;
        ctrl.alu_op        = ALU_OP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_src        = PC_SRC_ALUOUT;
      end
      S_ADDIEX: begin
        ctrl.alu_src_a = ALU_SRC_A_REG;
        ctrl.alu_src_b = ALU_SRC_B_IMM;
      end
      S_ADDIWB: begin
        ctrl.reg_write = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PC_SRC_JUMP;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ceyloniac_multicycle_ctrl_fsm.sv
// Main multicycle control FSM: state register, opcode-driven next-state
// logic and mem_ready / reset gating of the write enables.
module ceyloniac_multicycle_ctrl_fsm
  import ceyloniac_multicycle_ctrl_fsm_pkg::*;
#(
  parameter int OPCODE_WIDTH = 6
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    zero,
  input  logic                    mem_ready,
  output logic [1:0]              alu_src_b,
  output logic                    alu_src_a,
  output logic [1:0]              alu_op,
  output logic                    iord,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic                    ir_write,
  output logic                    reg_write,
  output logic                    reg_dst,
  output logic                    mem_to_reg,
  output logic                    pc_write,
  output logic                    pc_write_cond,
  output logic [1:0]              pc_src,
  output logic                    illegal_op,
  output logic [3:0]              state
);

  state_t     state_reg;
  state_t     state_next;
  ctrl_word_t ctrl;
  logic       fetch_done;
  logic       unused_zero;

  // Branch qualification by zero happens in the datapath.
  assign unused_zero = zero;

  ceyloniac_ctrl_output_decode u_output_decode (
    .state (state_reg),
    .ctrl  (ctrl)
  );

  // Next-state selection; opcode is only consulted in DECODE and MEMADR.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH:  if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXEC;
          OP_BEQ:       state_next = S_BRANCH;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JUMP;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR: state_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_next = S_MEMWB;
      S_MEMWB:  state_next = S_FETCH;
      S_MEMWR:  if (mem_ready) state_next = S_FETCH;
      S_EXEC:   state_next = S_ALUWB;
      S_ALUWB:  state_next = S_FETCH;
      S_BRANCH: state_next = S_FETCH;
      S_ADDIEX: state_next = S_ADDIWB;
      S_ADDIWB: state_next = S_FETCH;
      S_JUMP:   state_next = S_FETCH;
      default:  state_next = S_FETCH;
    endcase
  end

  // State register; reset aborts any instruction back to FETCH at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= S_FETCH;
    else          state_reg <= state_next;
  end

  // In FETCH the IR/PC loads only fire on the cycle memory delivers.
  assign fetch_done = (state_reg != S_FETCH) || mem_ready;

  // Enables are held low while reset is asserted so nothing is written.
  assign ir_write      = reset_n & ctrl.ir_write & fetch_done;
  assign pc_write      = reset_n & ctrl.pc_write & fetch_done;
  assign mem_read      = reset_n & ctrl.mem_read;
  assign mem_write     = reset_n & ctrl.mem_write;
  assign reg_write     = reset_n & ctrl.reg_write;
  assign pc_write_cond = reset_n & ctrl.pc_write_cond;

  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_op     = ctrl.alu_op;
  assign iord       = ctrl.iord;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign pc_src     = ctrl.pc_src;
  assign state      = state_reg;

  assign illegal_op = reset_n && (state_reg == S_DECODE) && !is_legal_op(opcode);

endmodule

// File: tb/tb_ceyloniac_multicycle_ctrl_fsm.sv
// Self-checking bench: instructions are expanded into expected per-cycle
// step lists from opcode and memory wait counts, then compared cycle by cycle.
`timescale 1ns/1ps
module tb_ceyloniac_multicycle_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic [1:0] alu_src_b;
  logic       alu_src_a;
  logic [1:0] alu_op;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       pc_write;
  logic       pc_write_cond;
  logic [1:0] pc_src;
  logic       illegal_op;
  logic [3:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int   st;
    logic mr;
  } step_t;

  step_t steps[$];

  always #5 clk = ~clk;

  ceyloniac_multicycle_ctrl_fsm #(.OPCODE_WIDTH(6)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .opcode        (opcode),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .alu_src_b     (alu_src_b),
    .alu_src_a     (alu_src_a),
    .alu_op        (alu_op),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_src        (pc_src),
    .illegal_op    (illegal_op),
    .state         (state)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] obs_word();
    return {11'b0, state, alu_src_b, alu_src_a, alu_op, iord, mem_read, mem_write,
            ir_write, reg_write, reg_dst, mem_to_reg, pc_write, pc_write_cond,
            pc_src, illegal_op};
  endfunction

  // Expected outputs for one cycle, taken from the per-state output table.
  function automatic logic [31:0] exp_word(input int st, input logic [5:0] op,
                                           input logic mr, input bit in_reset);
    logic [1:0] sb, aop, psrc;
    logic [3:0] st4;
    logic sa, io, mrd, mwr, irw, rw, rd, m2r, pw, pwc, ill;
    sb = 2'b00; aop = 2'b00; psrc = 2'b00;
    sa = 0; io = 0; mrd = 0; mwr = 0; irw = 0; rw = 0; rd = 0; m2r = 0;
    pw = 0; pwc = 0; ill = 0;
    case (st)
      0:  begin mrd = 1; sb = 2'b01; irw = mr; pw = mr; end
      1:  begin
            sb = 2'b11;
            ill = !(op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100,
                               6'b001000, 6'b000010});
          end
      2:  begin sa = 1; sb = 2'b10; end
      3:  begin mrd = 1; io = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; io = 1; end
      6:  begin sa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 1; end
      8:  begin sa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
      9:  begin sa = 1; sb = 2'b10; end
      10: begin rw = 1; end
      11: begin pw = 1; psrc = 2'b10; end
      default: ;
    endcase
    if (in_reset) begin
      mrd = 0; irw = 0; pw = 0; mwr = 0; rw = 0; pwc = 0;
    end
    st4 = st[3:0];
    return {11'b0, st4, sb, sa, aop, io, mrd, mwr, irw, rw, rd, m2r, pw, pwc, psrc, ill};
  endfunction

  // Called just after a falling edge: drive, settle, compare, move on.
  task automatic step_check(input int st, input logic mr, input logic [5:0] op,
                            input bit in_reset, input string tag);
    mem_ready = mr;
    opcode    = op;
    zero      = 1'($urandom_range(0, 1));
    #1;
    check_eq($sformatf("%s st%0d", tag, st), obs_word(), exp_word(st, op, mr, in_reset));
    @(negedge clk);
  endtask

  // Expand one instruction into its expected cycle sequence.
  task automatic build_steps(input logic [5:0] op, input int wf, input int wm);
    steps.delete();
    for (int i = 0; i < wf; i++) steps.push_back('{0, 1'b0});
    steps.push_back('{0, 1'b1});
    steps.push_back('{1, 1'($urandom_range(0, 1))});
    case (op)
      6'b100011: begin
        steps.push_back('{2, 1'($urandom_range(0, 1))});
        for (int i = 0; i < wm; i++) steps.push_back('{3, 1'b0});
        steps.push_back('{3, 1'b1});
        steps.push_back('{4, 1'($urandom_range(0, 1))});
      end
      6'b101011: begin
        steps.push_back('{2, 1'($urandom_range(0, 1))});
        for (int i = 0; i < wm; i++) steps.push_back('{5, 1'b0});
        steps.push_back('{5, 1'b1});
      end
      6'b000000: begin
        steps.push_back('{6, 1'($urandom_range(0, 1))});
        steps.push_back('{7, 1'($urandom_range(0, 1))});
      end
      6'b000100: steps.push_back('{8, 1'($urandom_range(0, 1))});
      6'b001000: begin
        steps.push_back('{9, 1'($urandom_range(0, 1))});
        steps.push_back('{10, 1'($urandom_range(0, 1))});
      end
      6'b000010: steps.push_back('{11, 1'($urandom_range(0, 1))});
      default: ;
    endcase
  endtask

  task automatic run_instr(input logic [5:0] op, input int wf, input int wm, input string name);
    int fails_before;
    fails_before = n_fail;
    build_steps(op, wf, wm);
    foreach (steps[i]) step_check(steps[i].st, steps[i].mr, op, 1'b0, name);
    $display("instr %-6s op=%b wf=%0d wm=%0d cycles=%0d errs=%0d",
             name, op, wf, wm, steps.size(), n_fail - fails_before);
  endtask

  initial begin
    logic [5:0] legal_ops [6];
    logic [5:0] op;
    int sel;
    legal_ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};

    reset_n = 1'b0; mem_ready = 1'b0; opcode = 6'b0; zero = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) step_check(0, 1'b1, 6'b100011, 1'b1, "reset");
    reset_n = 1'b1;

    // Directed sequences
    run_instr(6'b100011, 0, 0, "lw");
    run_instr(6'b101011, 0, 3, "sw");
    run_instr(6'b000000, 0, 0, "rtype");
    run_instr(6'b000100, 0, 0, "beq");
    run_instr(6'b000010, 0, 0, "j");
    run_instr(6'b111111, 0, 0, "illeg");
    run_instr(6'b001000, 2, 0, "addi");

    // lw aborted by reset while waiting in MEMRD
    step_check(0, 1'b1, 6'b100011, 1'b0, "abort");
    step_check(1, 1'b1, 6'b100011, 1'b0, "abort");
    step_check(2, 1'b0, 6'b100011, 1'b0, "abort");
    step_check(3, 1'b0, 6'b100011, 1'b0, "abort");
    step_check(3, 1'b0, 6'b100011, 1'b0, "abort");
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) step_check(0, 1'b1, 6'b100011, 1'b1, "abort_rst");
    reset_n = 1'b1;
    $display("instr abort  lw reset in MEMRD");

    // Randomized instruction stream
    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 7);
      if (sel < 6) op = legal_ops[sel];
      else         op = 6'($urandom_range(0, 63));
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
